menu_fsm: RTL and testbench

MENU_FSM -- requirements
Module: menu_fsm

---
 rtl/menu_fsm.sv | 166 ++++++++++++++++
 tb/tb_menu_fsm.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/menu_fsm.sv
// Menu controller: debounced key edges drive the Main/StartGame/Control/About/Exit screens.
// Optional build macro MENU_WRAP_EN makes cursor moves wrap instead of saturating.
module menu_fsm #(
  parameter int HOLDOFF_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_enter,
  input  logic       key_esc,
  input  logic       game_over,
  output logic [2:0] menu_state,
  output logic [1:0] menu_counter,
  output logic       game_start,
  output logic       game_quit
);

  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_MAIN    = 3'd0,
    ST_START   = 3'd1,
    ST_CONTROL = 3'd2,
    ST_ABOUT   = 3'd3,
    ST_EXIT    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          start_q, start_d;
  logic          quit_q, quit_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    keys_q;

  logic [3:0] keys_now;
  logic [3:0] edges;
  logic       accept;
  logic       ev_enter, ev_esc, ev_up, ev_down, ev_any;

  function automatic logic [1:0] cur_inc(input logic [1:0] cur, input logic [1:0] top);
`ifdef MENU_WRAP_EN
    return (cur == top) ? 2'd0 : cur + 2'd1;
`else
    return (cur == top) ? cur : cur + 2'd1;
`endif
  endfunction

  function automatic logic [1:0] cur_dec(input logic [1:0] cur, input logic [1:0] top);
`ifdef MENU_WRAP_EN
    return (cur == 2'd0) ? top : cur - 2'd1;
`else
    return (cur == 2'd0) ? cur : cur - 2'd1;
`endif
  endfunction

  // Edge detect: the current level is compared against the previous sample so
  // outputs react on the very edge that first sees the key high.
  assign keys_now = {key_enter, key_esc, key_up, key_down};
  assign edges    = keys_now & ~keys_q;
  assign accept   = (hold_q == '0);

  assign ev_enter = accept & edges[3];
  assign ev_esc   = accept & edges[2] & ~edges[3];
  assign ev_up    = accept & edges[1] & ~(|edges[3:2]);
  assign ev_down  = accept & edges[0] & ~(|edges[3:1]);
  assign ev_any   = accept & (|edges);

  always_comb begin
    hold_d = hold_q;
    if (ev_any) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    quit_d  = 1'b0;
    case (state_q)
      ST_MAIN: begin
        if (ev_enter) begin
          cnt_d = 2'd0;
          case (cnt_q)
            2'd0: begin
              state_d = ST_START;
              start_d = 1'b1;
            end
            2'd1:    state_d = ST_CONTROL;
            2'd2:    state_d = ST_ABOUT;
            default: state_d = ST_EXIT;
          endcase
        end else if (ev_up) begin
          cnt_d = cur_dec(cnt_q, 2'd3);
        end else if (ev_down) begin
          cnt_d = cur_inc(cnt_q, 2'd3);
        end
      end
      ST_START: begin
        if (game_over) begin
          state_d = ST_MAIN;
          cnt_d   = 2'd0;
        end
      end
      ST_CONTROL: begin
        if (ev_enter || ev_esc) begin
          state_d = ST_MAIN;
          cnt_d   = 2'd1;
        end
      end
      ST_ABOUT: begin
        if (ev_enter || ev_esc) begin
          state_d = ST_MAIN;
          cnt_d   = 2'd2;
        end
      end
      ST_EXIT: begin
        // Exit cursor: 0 = Yes (quit), 1 = No (back to Main on the Exit entry).
        if (ev_enter && cnt_q == 2'd0) begin
          state_d = ST_MAIN;
          cnt_d   = 2'd0;
          quit_d  = 1'b1;
        end else if (ev_enter || ev_esc) begin
          state_d = ST_MAIN;
          cnt_d   = 2'd3;
        end else if (ev_up) begin
          cnt_d = cur_dec(cnt_q, 2'd1);
        end else if (ev_down) begin
          cnt_d = cur_inc(cnt_q, 2'd1);
        end
      end
      default: begin
        state_d = ST_MAIN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_MAIN;
      cnt_q   <= 2'd0;
      start_q <= 1'b0;
      quit_q  <= 1'b0;
      hold_q  <= '0;
      keys_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      quit_q  <= quit_d;
      hold_q  <= hold_d;
      keys_q  <= keys_now;
    end
  end

  assign menu_state   = state_q;
  assign menu_counter = cnt_q;
  assign game_start   = start_q;
  assign game_quit    = quit_q;

endmodule

// File: tb/tb_menu_fsm.sv
// Scoreboard bench for menu_fsm with HOLDOFF_CYCLES=4; expectations are hand-computed per step.
module tb_menu_fsm;

  localparam logic [3:0] K_NONE = 4'b0000;
  localparam logic [3:0] K_DN   = 4'b0001;
  localparam logic [3:0] K_UP   = 4'b0010;
  localparam logic [3:0] K_ESC  = 4'b0100;
  localparam logic [3:0] K_ENT  = 4'b1000;

  logic       clk;
  logic       rst_n;
  logic       key_up, key_down, key_enter, key_esc, game_over;
  logic [2:0] menu_state;
  logic [1:0] menu_counter;
  logic       game_start, game_quit;

  logic [6:0] exp_q[$];
  string      nm_q[$];
  logic       done;
  logic       chk_req;
  int         n_cmp;
  int         n_bad;

  menu_fsm #(.HOLDOFF_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_up       (key_up),
    .key_down     (key_down),
    .key_enter    (key_enter),
    .key_esc      (key_esc),
    .game_over    (game_over),
    .menu_state   (menu_state),
    .menu_counter (menu_counter),
    .game_start   (game_start),
    .game_quit    (game_quit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus just after the falling edge and queue the
  // outputs expected after the following rising edge.
  task automatic step(input logic r, input logic [3:0] k, input logic go,
                      input logic [2:0] es, input logic [1:0] ec,
                      input logic egs, input logic egq, input string nm);
    @(negedge clk);
    #1;
    rst_n = r;
    {key_enter, key_esc, key_up, key_down} = k;
    game_over = go;
    exp_q.push_back({es, ec, egs, egq});
    nm_q.push_back(nm);
  endtask

  task automatic idle(input int n, input logic [2:0] es, input logic [1:0] ec);
    for (int i = 0; i < n; i++) step(1'b1, K_NONE, 1'b0, es, ec, 1'b0, 1'b0, "idle");
  endtask

  task automatic async_probe();
    #1 chk_req = 1'b1;
    #1 chk_req = 1'b0;
  endtask

  // Monitor: pops one expectation per falling edge, or checks the outputs
  // immediately when an asynchronous-reset probe is requested.
  initial begin
    logic [6:0] e;
    logic [6:0] got;
    string      nm;
    n_cmp = 0;
    n_bad = 0;
    while (!(done && exp_q.size() == 0)) begin
      @(negedge clk or posedge chk_req);
      got = {menu_state, menu_counter, game_start, game_quit};
      if (chk_req) begin
        n_cmp++;
        if (got !== 7'd0) begin
          n_bad++;
          $display("FAIL async_rst: got st=%0d cnt=%0d gs=%0b gq=%0b, expected all zero",
                   got[6:4], got[3:2], got[1], got[0]);
        end
      end else if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL %s: got st=%0d cnt=%0d gs=%0b gq=%0b, expected st=%0d cnt=%0d gs=%0b gq=%0b",
                   nm, got[6:4], got[3:2], got[1], got[0], e[6:4], e[3:2], e[1], e[0]);
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    done = 1'b0;
    chk_req = 1'b0;
    rst_n = 1'b1;
    {key_enter, key_esc, key_up, key_down} = K_NONE;
    game_over = 1'b0;
    #1 rst_n = 1'b0;
    async_probe();

    step(1'b0, K_NONE, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, "rst_hold");
    step(1'b1, K_NONE, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, "rst_release");

    // Main navigation, About and back.
    step(1'b1, K_DN,  1'b0, 3'd0, 2'd1, 1'b0, 1'b0, "main_down1"); idle(4, 3'd0, 2'd1);
    step(1'b1, K_DN,  1'b0, 3'd0, 2'd2, 1'b0, 1'b0, "main_down2"); idle(4, 3'd0, 2'd2);
    step(1'b1, K_ENT, 1'b0, 3'd3, 2'd0, 1'b0, 1'b0, "enter_about"); idle(4, 3'd3, 2'd0);
    step(1'b1, K_ESC, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0, "about_esc");   idle(4, 3'd0, 2'd2);

    // Cursor at the bottom end.
    step(1'b1, K_DN,  1'b0, 3'd0, 2'd3, 1'b0, 1'b0, "main_down3"); idle(4, 3'd0, 2'd3);
`ifdef MENU_WRAP_EN
    step(1'b1, K_DN,  1'b0, 3'd0, 2'd0, 1'b0, 1'b0, "main_wrap_down"); idle(4, 3'd0, 2'd0);
    step(1'b1, K_UP,  1'b0, 3'd0, 2'd3, 1'b0, 1'b0, "main_wrap_up");   idle(4, 3'd0, 2'd3);
`else
    step(1'b1, K_DN,  1'b0, 3'd0, 2'd3, 1'b0, 1'b0, "main_sat_down");  idle(4, 3'd0, 2'd3);
`endif

    // Exit, confirm quit.
    step(1'b1, K_ENT, 1'b0, 3'd4, 2'd0, 1'b0, 1'b0, "enter_exit"); idle(4, 3'd4, 2'd0);
    step(1'b1, K_ENT, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, "exit_quit");  idle(4, 3'd0, 2'd0);

    // Hold-off: second edge at +2 discarded, third at +5 accepted.
    step(1'b1, K_DN,   1'b0, 3'd0, 2'd1, 1'b0, 1'b0, "hold_first");
    step(1'b1, K_NONE, 1'b0, 3'd0, 2'd1, 1'b0, 1'b0, "hold_gap1");
    step(1'b1, K_DN,   1'b0, 3'd0, 2'd1, 1'b0, 1'b0, "hold_discard");
    step(1'b1, K_NONE, 1'b0, 3'd0, 2'd1, 1'b0, 1'b0, "hold_gap2");
    step(1'b1, K_NONE, 1'b0, 3'd0, 2'd1, 1'b0, 1'b0, "hold_gap3");
    step(1'b1, K_DN,   1'b0, 3'd0, 2'd2, 1'b0, 1'b0, "hold_accept"); idle(4, 3'd0, 2'd2);

    // Control screen.
    step(1'b1, K_UP,  1'b0, 3'd0, 2'd1, 1'b0, 1'b0, "main_up");     idle(4, 3'd0, 2'd1);
    step(1'b1, K_ENT, 1'b0, 3'd2, 2'd0, 1'b0, 1'b0, "enter_ctl");   idle(4, 3'd2, 2'd0);
    step(1'b1, K_UP,  1'b0, 3'd2, 2'd0, 1'b0, 1'b0, "ctl_up_ign");  idle(4, 3'd2, 2'd0);
    step(1'b1, K_ENT, 1'b0, 3'd0, 2'd1, 1'b0, 1'b0, "ctl_enter");   idle(4, 3'd0, 2'd1);
    step(1'b1, K_DN,  1'b0, 3'd0, 2'd2, 1'b0, 1'b0, "to2");         idle(4, 3'd0, 2'd2);
    step(1'b1, K_DN,  1'b0, 3'd0, 2'd3, 1'b0, 1'b0, "to3");         idle(4, 3'd0, 2'd3);

    // Exit, choose No; then Exit, escape.
    step(1'b1, K_ENT, 1'b0, 3'd4, 2'd0, 1'b0, 1'b0, "enter_exit2"); idle(4, 3'd4, 2'd0);
    step(1'b1, K_DN,  1'b0, 3'd4, 2'd1, 1'b0, 1'b0, "exit_no");     idle(4, 3'd4, 2'd1);
    step(1'b1, K_ENT, 1'b0, 3'd0, 2'd3, 1'b0, 1'b0, "exit_no_ent"); idle(4, 3'd0, 2'd3);
    step(1'b1, K_ENT, 1'b0, 3'd4, 2'd0, 1'b0, 1'b0, "enter_exit3"); idle(4, 3'd4, 2'd0);
    step(1'b1, K_ESC, 1'b0, 3'd0, 2'd3, 1'b0, 1'b0, "exit_esc");    idle(4, 3'd0, 2'd3);

    // Back to top, then enter+up together starts the game.
    step(1'b1, K_UP, 1'b0, 3'd0, 2'd2, 1'b0, 1'b0, "up_to2"); idle(4, 3'd0, 2'd2);
    step(1'b1, K_UP, 1'b0, 3'd0, 2'd1, 1'b0, 1'b0, "up_to1"); idle(4, 3'd0, 2'd1);
    step(1'b1, K_UP, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, "up_to0"); idle(4, 3'd0, 2'd0);
    step(1'b1, K_ENT | K_UP, 1'b0, 3'd1, 2'd0, 1'b1, 1'b0, "start_pri");
    step(1'b1, K_NONE, 1'b0, 3'd1, 2'd0, 1'b0, 1'b0, "start_pulse_end"); idle(3, 3'd1, 2'd0);
    step(1'b1, K_DN,   1'b0, 3'd1, 2'd0, 1'b0, 1'b0, "sg_key_ign");
    step(1'b1, K_NONE, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, "sg_game_over"); idle(4, 3'd0, 2'd0);
    step(1'b1, K_NONE, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, "main_go_ign");  idle(4, 3'd0, 2'd0);

    // Into Exit, then reset during hold-off with down held through release.
    step(1'b1, K_DN,  1'b0, 3'd0, 2'd1, 1'b0, 1'b0, "r_to1"); idle(4, 3'd0, 2'd1);
    step(1'b1, K_DN,  1'b0, 3'd0, 2'd2, 1'b0, 1'b0, "r_to2"); idle(4, 3'd0, 2'd2);
    step(1'b1, K_DN,  1'b0, 3'd0, 2'd3, 1'b0, 1'b0, "r_to3"); idle(4, 3'd0, 2'd3);
    step(1'b1, K_ENT, 1'b0, 3'd4, 2'd0, 1'b0, 1'b0, "r_exit");
    step(1'b0, K_DN,  1'b0, 3'd0, 2'd0, 1'b0, 1'b0, "r_async");
    async_probe();
    step(1'b1, K_DN,   1'b0, 3'd0, 2'd1, 1'b0, 1'b0, "held_key_evt");
    step(1'b1, K_NONE, 1'b0, 3'd0, 2'd1, 1'b0, 1'b0, "held_release");
    idle(2, 3'd0, 2'd1);
    done = 1'b1;
  end

endmodule
